// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first requesting lane after ptr, wrapping back to ptr last.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic               excl_owner,
    output logic [SEL_W-1:0]   pick,
    output logic               found
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // Offset NUM_REQ wraps to ptr itself, which is skipped when the owner is excluded.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx] && !(i == NUM_REQ && excl_owner)) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter owning a shared 4:1 mux, with a hold limit.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   d,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [SEL_W-1:0]           sel,
    output logic [WIDTH-1:0]           y,
    output logic                       busy
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t         state, state_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [7:0]         cnt, cnt_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic               busy_n;
    logic               excl_owner;
    logic [SEL_W-1:0]   pick;
    logic               found;
    logic               owner_req;

    rr_pick u_pick (
        .req        (req),
        .ptr        (ptr),
        .excl_owner (excl_owner),
        .pick       (pick),
        .found      (found)
    );

    assign owner_req = req[ptr];

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        gnt_n      = gnt;
        sel_n      = sel;
        busy_n     = busy;
        // While granted, ptr is the owner, so "found" means some other lane is waiting.
        excl_owner = (state == ST_GRANT);
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_n = ST_GRANT;
                    gnt_n   = onehot(pick);
                    sel_n   = pick;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    ptr_n   = pick;
                end
            end
            ST_GRANT: begin
                if (found && (!owner_req || cnt == HOLD_LAST)) begin
                    gnt_n = onehot(pick);
                    sel_n = pick;
                    cnt_n = '0;
                    ptr_n = pick;
                end else if (!owner_req) begin
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                end else if (!found) begin
                    if (cnt < HOLD_LAST) cnt_n = cnt + 8'd1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= SEL_W'(NUM_REQ - 1);
            cnt   <= '0;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            busy  <= busy_n;
        end
    end

    assign y = busy ? d[sel*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: vector table plus multi-cycle sequences.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] d = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [0:0] y;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       y;
    } vec_t;

    vec_t vecs[8];

    rr_mux_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_gnt"}, 32'(gnt), 32'h0);
        check({name, "_sel"}, 32'(sel), 32'h0);
        check({name, "_busy"}, 32'(busy), 32'h0);
        check({name, "_y"}, 32'(y), 32'h0);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
    task automatic do_reset(input logic [3:0] r);
        @(negedge clk);
        req = r;
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0000;
    endtask

    always @(negedge clk) begin
        check("inv_onehot0", 32'($onehot0(gnt)), 32'h1);
        check("inv_busy_gnt", 32'(busy), 32'(|gnt));
        if (busy) check("inv_sel_gnt", 32'(gnt), 32'(4'b0001 << sel));
    end

    initial begin
        int waited;
        logic [3:0] one;

        // MAX_HOLD=4 throughout; ptr starts at 3 after reset.
        vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[1] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[3] = '{4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[4] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[5] = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[6] = '{4'b1101, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};

        req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("init_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0000;

        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            d   = vecs[i].d;
            cycle();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
        end

        // Fair rotation: each owner drops for one cycle after its grant.
        do_reset(4'b1111);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            one = 4'b0001 << (k % 4);
            check($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(one));
            check($sformatf("rot%0d_busy", k), 32'(busy), 32'h1);
            req = 4'b1111 & ~one;
        end

        // Preemption between two continuous requesters every MAX_HOLD cycles.
        do_reset(4'b0011);
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check($sformatf("pre%0d_gnt", i), 32'(gnt), 32'(4'b0001 << ((i / 4) % 2)));
            check($sformatf("pre%0d_sel", i), 32'(sel), 32'((i / 4) % 2));
        end

        // Lone holder keeps its grant, then yields once another lane asks.
        do_reset(4'b1000);
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check($sformatf("lone%0d_gnt", i), 32'(gnt), 32'h8);
        end
        req = 4'b1010;
        waited = 0;
        do begin
            cycle();
            waited++;
        end while (gnt !== 4'b0010 && waited < 4);
        check("lone_yield_gnt", 32'(gnt), 32'h2);
        check("lone_yield_cycles", 32'(waited), 32'h1);

        // Reset while lane 1 owns the mux, then re-arbitrate from scratch.
        do_reset(4'b1111);
        req = 4'b1000;
        d   = 4'b1000;
        cycle();
        check("post_reset_gnt", 32'(gnt), 32'h8);
        check("post_reset_sel", 32'(sel), 32'h3);
        check("post_reset_y", 32'(y), 32'h1);
        d = 4'b0111;
        #1;
        check("comb_y_path", 32'(y), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
